// File: rtl/osecpu_pkg.sv
// osecpu_pkg: shared widths and the fetch state encoding
package osecpu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    typedef enum logic {RUN, STOPPED} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of {data,pc} words with flush; head readable combinationally
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // storage and pointers; flush wins over push/pop, push into a full buffer relies on a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction prefetcher with redirect, halt and shared memory port
module instr_fetch import osecpu_pkg::*; #(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      bus_gnt,
    output logic                      fetch_req,
    output logic                      instr_valid,
    output logic [DATA_W-1:0]         instr_data,
    output logic [ADDR_W-1:0]         instr_pc,
    input  logic                      instr_ready,
    input  logic                      jump_valid,
    input  logic [ADDR_W-1:0]         jump_addr,
    input  logic                      halt,
    output logic [$clog2(DEPTH):0]    count
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              full, empty, pop, fire;
    assign mem_addr    = pc;
    assign instr_valid = ~empty;
    assign pop         = instr_valid & instr_ready;
    assign fetch_req   = rst_n & (state == RUN) & ~halt & ~jump_valid & (~full | pop);
    assign fire        = fetch_req & bus_gnt;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end
    // halt always parks the fetcher; only a jump brings it back to RUN
    always_comb begin
        state_nxt = state;
        state_nxt = halt ? STOPPED : (jump_valid ? RUN : state);
    end
    // next fetch address: redirect has priority, otherwise advance on each granted fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pc <= RESET_PC;
        else if (jump_valid) pc <= jump_addr;
        else if (fire)       pc <= pc + 1'b1;
    end
    fetch_fifo #(.DEPTH(DEPTH), .W(DATA_W + ADDR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (pop),
        .flush (jump_valid),
        .wdata ({mem_data, pc}),
        .rdata ({instr_data, instr_pc}),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule
